// File: rtl/tmds_video_encoder.sv
`default_nettype none
// ============================================================================
// tmds_video_encoder
//   N-channel DC-balanced TMDS encoder with optional preamble/guard-band insertion.
//   Revision: 1.0
// ============================================================================
module tmds_video_encoder #(
  parameter int p_channels   = 3,
  parameter bit p_guard_mode = 1'b0
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_hsync,
  input  logic                       i_vsync,
  input  logic                       i_blank,
  input  logic [p_channels-1:0][7:0] i_data,
  output logic [p_channels-1:0][9:0] o_symbol,
  output logic                       o_blank
);

  localparam logic [9:0] CTL_IDLE = 10'b1101010100;

  if (p_channels < 1 || p_channels > 8) begin : g_bad_channels
    $error("tmds_video_encoder: p_channels must be in 1..8");
  end
  if (p_guard_mode && p_channels != 3) begin : g_bad_guard
    $error("tmds_video_encoder: guard mode requires p_channels == 3");
  end

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  function automatic logic [8:0] min_transition(input logic [7:0] d);
    logic [8:0] q;
    logic [3:0] n;
    logic       use_xnor;
    n        = ones8(d);
    use_xnor = (n > 4'd4) || (n == 4'd4 && !d[0]);
    q        = '0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = ~use_xnor;
    return q;
  endfunction

  function automatic logic [9:0] ctl_symbol(input logic [1:0] c);
    logic [9:0] s;
    case (c)
      2'b00:   s = 10'b1101010100;
      2'b01:   s = 10'b0010101011;
      2'b10:   s = 10'b0101010100;
      default: s = 10'b1010101011;
    endcase
    return s;
  endfunction

  logic                       dl_blank, dl_hsync, dl_vsync;
  logic [p_channels-1:0][7:0] dl_data;
  logic                       in_preamble, in_guard;
  logic                       s1_blank, s1_hsync, s1_vsync;
  logic [p_channels-1:0][8:0] s1_qm;
  logic                       s2_blank;

  if (p_guard_mode) begin : g_delay
    localparam int DEPTH = 10;
    logic [DEPTH-1:0]                       blank_sr, hsync_sr, vsync_sr;
    logic [DEPTH-1:0][p_channels-1:0][7:0] data_sr;
    logic                                   prev_blank;
    logic [3:0]                             k;

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        blank_sr <= '1;
        hsync_sr <= '0;
        vsync_sr <= '0;
        data_sr  <= '0;
      end else begin
        blank_sr <= {blank_sr[DEPTH-2:0], i_blank};
        hsync_sr <= {hsync_sr[DEPTH-2:0], i_hsync};
        vsync_sr <= {vsync_sr[DEPTH-2:0], i_vsync};
        data_sr  <= {data_sr[DEPTH-2:0], i_data};
      end
    end

    // k counts down toward the first active pixel as it reaches stage 2.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        prev_blank <= 1'b1;
        k          <= 4'd0;
      end else begin
        prev_blank <= i_blank;
        if (prev_blank && !i_blank) k <= 4'd10;
        else if (k != 4'd0)         k <= k - 4'd1;
      end
    end

    assign dl_blank    = blank_sr[DEPTH-1];
    assign dl_hsync    = hsync_sr[DEPTH-1];
    assign dl_vsync    = vsync_sr[DEPTH-1];
    assign dl_data     = data_sr[DEPTH-1];
    assign in_preamble = s1_blank && (k >= 4'd3);
    assign in_guard    = s1_blank && (k == 4'd1 || k == 4'd2);
  end else begin : g_direct
    assign dl_blank    = i_blank;
    assign dl_hsync    = i_hsync;
    assign dl_vsync    = i_vsync;
    assign dl_data     = i_data;
    assign in_preamble = 1'b0;
    assign in_guard    = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_blank <= 1'b1;
      s1_hsync <= 1'b0;
      s1_vsync <= 1'b0;
      s1_qm    <= '0;
      s2_blank <= 1'b1;
    end else begin
      s1_blank <= dl_blank;
      s1_hsync <= dl_hsync;
      s1_vsync <= dl_vsync;
      for (int ch = 0; ch < p_channels; ch++) s1_qm[ch] <= min_transition(dl_data[ch]);
      s2_blank <= s1_blank;
    end
  end

  assign o_blank = s2_blank;

  for (genvar ch = 0; ch < p_channels; ch++) begin : g_ch
    localparam bit         SYNC_CH = (ch == 0) || !p_guard_mode;
    localparam logic [9:0] GB_SYM  = (ch == 1) ? 10'b0100110011 : 10'b1011001100;

    logic [8:0]        qm;
    logic [3:0]        n1, n0;
    logic signed [4:0] diff, cnt, cnt_next;
    logic [1:0]        ctl;
    logic [9:0]        sym, sym_next;

    assign qm   = s1_qm[ch];
    assign n1   = ones8(qm[7:0]);
    assign n0   = 4'd8 - n1;
    assign diff = $signed({1'b0, n1}) - $signed({1'b0, n0});

    always_comb begin
      ctl = 2'b00;
      if (SYNC_CH)                      ctl = {s1_vsync, s1_hsync};
      else if (ch == 1 && in_preamble)  ctl = 2'b01;
    end

    always_comb begin
      sym_next = ctl_symbol(ctl);
      cnt_next = 5'sd0;
      if (s1_blank) begin
        if (in_guard) sym_next = GB_SYM;
      end else if (cnt == 5'sd0 || n1 == n0) begin
        sym_next = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
        cnt_next = qm[8] ? cnt + diff : cnt - diff;
      end else if ((cnt > 5'sd0 && n1 > n0) || (cnt < 5'sd0 && n0 > n1)) begin
        sym_next = {1'b1, qm[8], ~qm[7:0]};
        cnt_next = cnt + (qm[8] ? 5'sd2 : 5'sd0) - diff;
      end else begin
        sym_next = {1'b0, qm[8], qm[7:0]};
        cnt_next = cnt - (qm[8] ? 5'sd0 : 5'sd2) + diff;
      end
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        cnt <= 5'sd0;
        sym <= CTL_IDLE;
      end else begin
        cnt <= cnt_next;
        sym <= sym_next;
      end
    end

    assign o_symbol[ch] = sym;
  end

endmodule
`default_nettype wire

// File: doc/tmds_video_encoder.md
# tmds_video_encoder

Parametrised, single-clock TMDS encoder for N video channels. It produces DC-balanced 10-bit symbols at pixel rate, with optional HDMI-style video preamble and guard-band insertion ahead of every active-video period. It sits between the VGA timing generator and the per-channel serializers, replacing the fixed three-channel DVI-only encoding path.

## Interface
- p_channels, 3, number of encoded channels (1..8); channel 0 carries hsync/vsync.
- p_guard_mode, 1'b0, 0 = plain DVI; 1 = insert 8-cycle preamble plus 2-cycle guard band before active video (requires p_channels == 3, elaboration error otherwise).
- i_clk  input  1  pixel clock; the only clock.
- i_rst  input  1  synchronous, active-high reset.
- i_hsync  input  1  horizontal sync, sampled every cycle.
- i_vsync  input  1  vertical sync.
- i_blank  input  1  1 = control period, 0 = active video.
- i_data  input  [p_channels][8]  pixel byte per channel.
- o_symbol  output  [p_channels][10]  TMDS symbol per channel; bit 0 is transmitted first.
- o_blank  output  1  i_blank delayed to align with o_symbol.

## Operation
- Stage 1 (registered): per-channel count of ones N1(d). If N1 > 4, or N1 == 4 with d[0] == 0, q_m is built by XNOR chaining and q_m[8] = 0. Otherwise q_m is built by XOR chaining and q_m[8] = 1.
- Stage 2 (registered): per-channel running disparity cnt, signed 5-bit, with standard DVI 1.0 balancing.
  - cnt == 0 or N1(q_m) == N0(q_m): out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}. cnt += q_m[8] ? N1-N0 : N0-N1.
  - (cnt > 0 and N1 > N0) or (cnt < 0 and N0 > N1): out = {1, q_m[8], ~q_m[7:0]}. cnt += 2*q_m[8] + N0 - N1.
  - Otherwise: out = {0, q_m[8], q_m[7:0]}. cnt += -2*~q_m[8] + N1 - N0.
- Control period (blank = 1 at stage 2): cnt is forced to 0.
- Control symbols for {c1,c0}: 00 → 1101010100, 01 → 0010101011, 10 → 0101010100, 11 → 1010101011.
  - Channel 0 uses {vsync,hsync}.
  - With p_guard_mode = 0, channels ≥ 1 also use {vsync,hsync}.
  - With p_guard_mode = 1, channels 1 and 2 use CTL = 00 outside preamble.
- Guard mode:
  - Video path (data, syncs, blank) is delayed by 10 extra registers.
  - A rising edge of ~i_blank at the input loads a 4-bit countdown k = 10. k decrements every cycle until 0.
  - While k != 0 and the delayed blank == 1, the output is overridden:
    - k ∈ 10..3: preamble. Channel 1 CTL {c1,c0} = 01, channel 2 CTL = 00, channel 0 keeps syncs.
    - k ∈ 2..1: guard band. Channel 0 = 1011001100, channel 1 = 0100110011, channel 2 = 1011001100.
  - Active-video symbols (delayed blank == 0) are never overridden. With input blanking shorter than 10 cycles, the override occupies only the blank cycles that exist, and the guard band still lands on the last ≤2 blank cycles.
  - A new falling edge of i_blank while k != 0 reloads k = 10.
  - Override and cnt reset do not interact; cnt is already 0 in blanking.

## Timing
- Latency i_* → o_symbol/o_blank: 2 cycles (p_guard_mode = 0), 12 cycles (p_guard_mode = 1). Throughput is one symbol per channel per cycle, with no stalls.
- Reset: all pipeline registers load blank = 1, hsync = vsync = 0, data = 0. cnt = 0, k = 0.
  - o_symbol = 1101010100 on every channel and o_blank = 1 from the cycle after i_rst is sampled high until the flushed pipeline emits post-reset input.
- Reset asserted mid-line or mid-preamble aborts the sequence. There is no partial guard band after release unless a fresh falling edge of i_blank is seen.
- Arithmetic: N1/N0 are 4-bit unsigned; cnt is 5-bit two's complement and never exceeds ±10 for legal streams.

## Test plan
- Reset then idle blank with hsync = vsync = 0 → every channel emits 1101010100; o_blank = 1.
- Blank with {vsync,hsync} cycling 00, 01, 10, 11 → channel 0 emits the four control codes in order, 2 cycles later (DVI mode).
- DVI mode, blank → active with data 0x00 on two consecutive pixels → symbols 0x100 then 0x3FF.
- DVI mode, first active pixel 0xFF after blank → symbol 0x200. Random 1000-pixel line → decoded bytes match input, and |cnt| ≤ 10 is checked against a reference model.
- Guard mode, blank of 20 cycles then active → output blank cycles 11..18 show channel 1 = 0010101011 and channel 2 = 1101010100. Cycles 19..20 show 1011001100 / 0100110011 / 1011001100. First pixel appears at latency 12.
- Guard mode, blank of only 4 cycles → only 4 overridden cycles; the last two are guard band, and no active pixel is altered.
